// File: rtl/dmem_lsu.sv
// Word-organised data memory with RISC-V byte/half/word load-store sizing.
// A hardware sequencer zeroes every word after reset before requests are accepted.
module dmem_lsu #(
  parameter int ADDR_W = 13
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  output logic        o_ready,
  output logic        o_ld_valid,
  output logic [31:0] o_ld_data,
  output logic        o_err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;

  logic [ADDR_W-1:0]   word_idx;
  logic [1:0]          lane;
  logic                out_of_range;
  logic                bad;
  logic                accept;

  logic [3:0]          we;
  logic [31:0]         wdata;
  logic [ADDR_W-1:0]   wr_idx;

  logic [31:0]         rd_word;
  logic [31:0]         rd_shift;
  logic [31:0]         ld_ext;

  assign word_idx     = i_lsu_addr[ADDR_W+1:2];
  assign lane         = i_lsu_addr[1:0];
  assign out_of_range = |i_lsu_addr[31:ADDR_W+2];
  assign accept       = i_req & o_ready;

  // Request legality: size code, store-only restrictions, alignment and range.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    bad = 1'b0;
    case (i_funct3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = lane[0];
      3'b010:  bad = |lane;
      3'b100:  bad = i_wren;
      3'b101:  bad = i_wren | lane[0];
      default: bad = 1'b1;
    endcase
    bad = bad | out_of_range;
  end

  // Write port is shared between the init sequencer and accepted stores.
  always_comb begin
    we     = 4'b0000;
    wdata  = 32'h0;
    wr_idx = word_idx;
    if (!i_reset) begin
      if (state == INIT) begin
        we     = 4'b1111;
        wr_idx = cnt;
      end else if (accept && i_wren && !bad) begin
        case (i_funct3[1:0])
          2'b00: begin
            we    = 4'b0001 << lane;
            wdata = {4{i_st_data[7:0]}};
          end
          2'b01: begin
            we    = lane[1] ? 4'b1100 : 4'b0011;
            wdata = {2{i_st_data[15:0]}};
          end
          default: begin
            we    = 4'b1111;
            wdata = i_st_data;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] bytes [DEPTH];

    // NOTE: the arrays carry no reset; the init sequencer clears them instead.
    always_ff @(posedge i_clk) begin
      if (we[g]) bytes[wr_idx] <= wdata[8*g +: 8];
    end

    assign rd_word[8*g +: 8] = bytes[word_idx];
  end

  // Legal halfword lanes are 0 or 2, so the shifted low half is always the target.
  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    ld_ext = rd_word;
    case (i_funct3)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
      default: ld_ext = rd_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= INIT;
      cnt        <= '0;
      o_ready    <= 1'b0;
      o_ld_valid <= 1'b0;
      o_ld_data  <= 32'h0;
      o_err      <= 1'b0;
    end else begin
      o_ld_valid <= 1'b0;
      o_err      <= 1'b0;
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == {ADDR_W{1'b1}}) begin
            state   <= RUN;
            o_ready <= 1'b1;
          end
        end
        RUN: begin
          if (i_req) begin
            if (bad) begin
              o_err <= 1'b1;
            end else if (!i_wren) begin
              o_ld_valid <= 1'b1;
              o_ld_data  <= ld_ext;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
